// File: rtl/song_playback_scheduler_pkg.sv
// rtl/song_playback_scheduler_pkg.sv - shared state encoding and defaults for the song playback scheduler
package song_playback_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH_A = 3'd1,
    S_FETCH_D = 3'd2,
    S_WAIT    = 3'd3,
    S_PAUSED  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam int DEFAULT_TICK_DIV  = 50;
  localparam int DEFAULT_TIME_BITS = 29;
  localparam int DEFAULT_MAX_TIME  = 300000000;
  localparam int DEFAULT_ADDR_BITS = 8;
  localparam int DEFAULT_KEY_BITS  = 5;

  localparam logic [DEFAULT_KEY_BITS-1:0] SENTINEL_KEY = '1;

endpackage

// File: rtl/song_playback_scheduler_us_timebase.sv
// rtl/song_playback_scheduler_us_timebase.sv - prescaler plus saturating microsecond counter
module us_timebase #(
  parameter int TICK_DIV  = 50,
  parameter int TIME_BITS = 29,
  parameter int MAX_TIME  = 300000000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 run,
  input  logic                 clear,
  output logic [TIME_BITS-1:0] elapsed_us,
  output logic                 tick,
  output logic                 at_max
);

  localparam int PRE_BITS = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_BITS-1:0]  PRE_LAST = PRE_BITS'(TICK_DIV - 1);
  localparam logic [TIME_BITS-1:0] T_LAST   = TIME_BITS'(MAX_TIME - 1);
  localparam logic [TIME_BITS-1:0] T_MAX    = TIME_BITS'(MAX_TIME);

  logic [PRE_BITS-1:0] prescaler;

  assign tick   = run && (prescaler == PRE_LAST);
  // at_max flags that the next tick would carry elapsed_us past the ceiling
  assign at_max = (elapsed_us >= T_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prescaler  <= '0;
      elapsed_us <= '0;
    end else if (clear) begin
      prescaler  <= '0;
      elapsed_us <= '0;
    end else if (run) begin
      if (tick) begin
        prescaler  <= '0;
        elapsed_us <= at_max ? T_MAX : elapsed_us + TIME_BITS'(1);
      end else begin
        prescaler <= prescaler + PRE_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/song_playback_scheduler.sv
// rtl/song_playback_scheduler.sv - walks a song ROM against a microsecond timebase, with start/pause/resume/stop
module song_playback_scheduler
  import song_playback_scheduler_pkg::*;
#(
  parameter int TICK_DIV  = DEFAULT_TICK_DIV,
  parameter int TIME_BITS = DEFAULT_TIME_BITS,
  parameter int MAX_TIME  = DEFAULT_MAX_TIME,
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int KEY_BITS  = DEFAULT_KEY_BITS
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic                          pause,
  input  logic                          stop,
  output logic [ADDR_BITS-1:0]          rom_addr,
  input  logic [TIME_BITS+KEY_BITS-1:0] rom_data,
  output logic                          note_valid,
  output logic [KEY_BITS-1:0]           note_key,
  output logic [TIME_BITS-1:0]          elapsed_us,
  output logic                          busy,
  output logic                          done,
  output logic                          timeout
);

  localparam logic [KEY_BITS-1:0]  SENT      = '1;
  localparam logic [ADDR_BITS-1:0] ADDR_LAST = '1;

  state_t              state;
  logic [TIME_BITS-1:0] ev_time;
  logic [KEY_BITS-1:0]  ev_key;
  logic                 tb_clear;
  logic                 tb_tick;
  logic                 tb_at_max;
  logic                 timeout_now;
  logic                 idle_or_done;

  assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
  assign tb_clear     = stop || (start && idle_or_done);
  // busy mirrors FETCH_A/FETCH_D/WAIT, so it doubles as the timebase run enable
  assign timeout_now  = tb_tick && tb_at_max;

  us_timebase #(
    .TICK_DIV  (TICK_DIV),
    .TIME_BITS (TIME_BITS),
    .MAX_TIME  (MAX_TIME)
  ) u_timebase (
    .clk        (clk),
    .resetn     (resetn),
    .run        (busy),
    .clear      (tb_clear),
    .elapsed_us (elapsed_us),
    .tick       (tb_tick),
    .at_max     (tb_at_max)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      rom_addr   <= '0;
      ev_time    <= '0;
      ev_key     <= '0;
      note_key   <= '0;
      note_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      note_valid <= 1'b0;
      if (stop) begin
        state    <= S_IDLE;
        rom_addr <= '0;
        ev_time  <= '0;
        ev_key   <= '0;
        note_key <= '0;
        busy     <= 1'b0;
        done     <= 1'b0;
        timeout  <= 1'b0;
      end else if (timeout_now) begin
        // the ceiling beats both a due note and a pause request on the same cycle
        state   <= S_DONE;
        ev_time <= '0;
        ev_key  <= '0;
        busy    <= 1'b0;
        done    <= 1'b1;
        timeout <= 1'b1;
      end else if (pause && busy) begin
        state   <= S_PAUSED;
        ev_time <= '0;
        ev_key  <= '0;
        busy    <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              state    <= S_FETCH_A;
              rom_addr <= '0;
              timeout  <= 1'b0;
              busy     <= 1'b1;
              done     <= 1'b0;
            end
          end
          S_PAUSED: begin
            if (start && !pause) begin
              state <= S_FETCH_A;
              busy  <= 1'b1;
            end
          end
          S_FETCH_A: state <= S_FETCH_D;
          S_FETCH_D: begin
            ev_time <= rom_data[TIME_BITS+KEY_BITS-1:KEY_BITS];
            ev_key  <= rom_data[KEY_BITS-1:0];
            if (rom_data[KEY_BITS-1:0] == SENT) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (elapsed_us >= ev_time) begin
              note_valid <= 1'b1;
              note_key   <= ev_key;
              if (rom_addr == ADDR_LAST) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                rom_addr <= rom_addr + ADDR_BITS'(1);
                state    <= S_FETCH_A;
              end
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_playback_scheduler.sv
// tb/tb_song_playback_scheduler.sv - scoreboard bench for song_playback_scheduler
module tb_song_playback_scheduler;

  localparam int D    = 4;
  localparam int MAXT = 60;
  localparam int TB   = 29;
  localparam int KB   = 5;
  localparam int AB   = 8;
  localparam int SENT = 31;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic stop = 1'b0;
  logic [AB-1:0]    rom_addr;
  logic [TB+KB-1:0] rom_data;
  logic             note_valid;
  logic [KB-1:0]    note_key;
  logic [TB-1:0]    elapsed_us;
  logic             busy;
  logic             done;
  logic             timeout;

  logic [TB+KB-1:0] rom [0:255];
  int ev_t [16];
  int ev_k [16];
  int n_ev;
  int exp_key [$];
  int exp_el [$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  song_playback_scheduler #(
    .TICK_DIV  (D),
    .TIME_BITS (TB),
    .MAX_TIME  (MAXT),
    .ADDR_BITS (AB),
    .KEY_BITS  (KB)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .note_valid (note_valid),
    .note_key   (note_key),
    .elapsed_us (elapsed_us),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && note_valid) begin
      if (exp_key.size() == 0) begin
        chk("unexpected_strobe", note_key, -1);
      end else begin
        int k;
        int e;
        k = exp_key.pop_front();
        e = exp_el.pop_front();
        chk("note_key", note_key, k);
        chk("note_elapsed", elapsed_us, e);
      end
    end
  end

  task automatic load_rom();
    for (int i = 0; i < n_ev; i++) rom[i] = {TB'(ev_t[i]), KB'(ev_k[i])};
  endtask

  // Running-cycle model: cycle 1 is the first busy cycle, elapsed at cycle c is (c-1)/D.
  // An event fetched at cycle a is checked from a+2 and fires once elapsed reaches its time.
  task automatic model(input int p, input bit push, output int end_c, output bit to);
    int a;
    int i;
    int e;
    int w;
    int tm;
    bit pend;
    a = 1;
    i = 0;
    w = 0;
    tm = MAXT * D;
    pend = (p > 0);
    forever begin
      if (ev_k[i] == SENT) begin
        e = a + 1;
      end else begin
        w = ev_t[i] * D + 1;
        if (w < a + 2) w = a + 2;
        e = w;
      end
      if (pend && p <= e && p < tm) begin
        pend = 1'b0;
        a = p + 1;
      end else if (tm <= e) begin
        end_c = tm;
        to = 1'b1;
        return;
      end else if (ev_k[i] == SENT) begin
        end_c = e;
        to = 1'b0;
        return;
      end else begin
        if (push) begin
          exp_key.push_back(ev_k[i]);
          exp_el.push_back(w / D);
        end
        a = w + 1;
        i++;
      end
    end
  endtask

  task automatic run(input int p, input int l);
    int end_c;
    int c;
    int ec;
    bit to;
    load_rom();
    model(p, 1'b1, end_c, to);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_timeout_clear", timeout, 0);
    chk("start_elapsed_zero", elapsed_us, 0);
    chk("start_busy", busy, 1);
    c = 1;
    while (!done && c < 3000) begin
      pause = (p > 0) && (c == p || c == p + 2);
      start = (p > 0) && (c == p + 2 || c == p + l);
      if (p > 0 && c > p && c <= p + l) chk("pause_hold_elapsed", elapsed_us, p / D);
      if (p > 0 && c == p + 3) chk("paused_not_busy", {busy, done}, 0);
      @(negedge clk);
      c++;
    end
    pause = 1'b0;
    start = 1'b0;
    ec = end_c + 1 + ((p > 0) ? l : 0);
    chk("done_cycle", c, ec);
    chk("end_timeout", timeout, to);
    chk("end_elapsed", elapsed_us, to ? MAXT : end_c / D);
    chk("end_busy", busy, 0);
    chk("strobes_left", exp_key.size(), 0);
    exp_key.delete();
    exp_el.delete();
  endtask

  task automatic stop_test(input bit all_cmds);
    n_ev = 2;
    ev_t[0] = 30; ev_k[0] = 5;
    ev_t[1] = 0;  ev_k[1] = SENT;
    load_rom();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("stop_pre_busy", busy, 1);
    stop = 1'b1;
    pause = all_cmds;
    start = all_cmds;
    @(negedge clk);
    stop = 1'b0;
    pause = 1'b0;
    start = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_done", done, 0);
    chk("stop_elapsed", elapsed_us, 0);
    chk("stop_rom_addr", rom_addr, 0);
    repeat (150) @(negedge clk);
    chk("stop_idle_elapsed", elapsed_us, 0);
  endtask

  initial begin
    int end_c;
    bit to;
    int p;
    int t;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_note_valid", note_valid, 0);
    chk("rst_note_key", note_key, 0);
    chk("rst_elapsed", elapsed_us, 0);
    chk("rst_rom_addr", rom_addr, 0);
    resetn = 1'b1;

    n_ev = 3;
    ev_t[0] = 2; ev_k[0] = 3;
    ev_t[1] = 5; ev_k[1] = 7;
    ev_t[2] = 0; ev_k[2] = SENT;
    run(0, 0);

    n_ev = 4;
    ev_t[0] = 1; ev_k[0] = 1;
    ev_t[1] = 1; ev_k[1] = 2;
    ev_t[2] = 1; ev_k[2] = 4;
    ev_t[3] = 0; ev_k[3] = SENT;
    run(0, 0);

    n_ev = 2;
    ev_t[0] = 5; ev_k[0] = 9;
    ev_t[1] = 0; ev_k[1] = SENT;
    run(13, 40);

    ev_t[0] = 70; ev_k[0] = 1;
    run(0, 0);

    // reset asserted mid-run in FETCH_D of the second event
    n_ev = 3;
    ev_t[0] = 2; ev_k[0] = 3;
    ev_t[1] = 5; ev_k[1] = 7;
    ev_t[2] = 0; ev_k[2] = SENT;
    load_rom();
    model(0, 1'b1, end_c, to);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_rom_addr", rom_addr, 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_note_key", note_key, 0);
    chk("async_rst_elapsed", elapsed_us, 0);
    chk("async_rst_rom_addr", rom_addr, 0);
    chk("async_rst_done_timeout", {done, timeout}, 0);
    @(negedge clk);
    resetn = 1'b1;
    exp_key.delete();
    exp_el.delete();

    stop_test(1'b0);
    stop_test(1'b1);

    for (int r = 0; r < 10; r++) begin
      n_ev = $urandom_range(1, 4);
      t = 0;
      for (int i = 0; i < n_ev; i++) begin
        t = t + $urandom_range(0, (r % 3 == 2) ? 25 : 6);
        ev_t[i] = t;
        ev_k[i] = $urandom_range(0, 30);
      end
      ev_t[n_ev] = 0;
      ev_k[n_ev] = SENT;
      n_ev = n_ev + 1;
      model(0, 1'b0, end_c, to);
      p = 0;
      if ($urandom_range(0, 1) == 1) p = $urandom_range(1, to ? MAXT * D - 1 : end_c);
      run(p, $urandom_range(5, 30));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
